// File: rtl/busca_vizinhos_if.sv
// Bus bundle for busca_vizinhos: start/status, adjacency and distance memory
// ports, and the operand/result pair of the external relaxation PE.
// Optional macro BUSCA_ANTECESSOR_EN adds the predecessor write-back pair.
//
// Handshake semantics: start_in is a level request sampled only while the
// block is idle; every *_rd_en_out is a one-cycle pulse and the matching
// *_rd_data_in must be valid during the following cycle; dist_wr_en_out is a
// one-cycle pulse that commits dist_wr_data_out at dist_addr_out.
interface busca_vizinhos_if #(
    parameter int DIST_WIDTH   = 8,
    parameter int CUSTO_WIDTH  = 8,
    parameter int NO_WIDTH     = 5,
    parameter int MAX_VIZINHOS = 4
);
    localparam int SLOT_W = $clog2(MAX_VIZINHOS);

    logic                            start_in;
    logic [NO_WIDTH-1:0]             no_id_in;
    logic                            busy_out;
    logic                            done_out;
    logic                            adj_rd_en_out;
    logic [NO_WIDTH+SLOT_W-1:0]      adj_addr_out;
    logic [NO_WIDTH+CUSTO_WIDTH:0]   adj_rd_data_in;
    logic                            dist_rd_en_out;
    logic [NO_WIDTH-1:0]             dist_addr_out;
    logic [DIST_WIDTH-1:0]           dist_rd_data_in;
    logic                            dist_wr_en_out;
    logic [DIST_WIDTH-1:0]           dist_wr_data_out;
    logic [DIST_WIDTH-1:0]           dist_no_out;
    logic [CUSTO_WIDTH-1:0]          custo_vizinho_out;
    logic [DIST_WIDTH-1:0]           dist_vizinho_out;
    logic                            update_in;
    logic [DIST_WIDTH-1:0]           nova_dist_in;
    logic [SLOT_W:0]                 relax_count_out;
`ifdef BUSCA_ANTECESSOR_EN
    logic                            pred_wr_en_out;
    logic [NO_WIDTH-1:0]             pred_wr_data_out;

    modport master (
        input  start_in, no_id_in, adj_rd_data_in, dist_rd_data_in, update_in, nova_dist_in,
        output busy_out, done_out, adj_rd_en_out, adj_addr_out, dist_rd_en_out, dist_addr_out,
               dist_wr_en_out, dist_wr_data_out, dist_no_out, custo_vizinho_out,
               dist_vizinho_out, relax_count_out, pred_wr_en_out, pred_wr_data_out
    );
    modport slave (
        output start_in, no_id_in, adj_rd_data_in, dist_rd_data_in, update_in, nova_dist_in,
        input  busy_out, done_out, adj_rd_en_out, adj_addr_out, dist_rd_en_out, dist_addr_out,
               dist_wr_en_out, dist_wr_data_out, dist_no_out, custo_vizinho_out,
               dist_vizinho_out, relax_count_out, pred_wr_en_out, pred_wr_data_out
    );
`else
    modport master (
        input  start_in, no_id_in, adj_rd_data_in, dist_rd_data_in, update_in, nova_dist_in,
        output busy_out, done_out, adj_rd_en_out, adj_addr_out, dist_rd_en_out, dist_addr_out,
               dist_wr_en_out, dist_wr_data_out, dist_no_out, custo_vizinho_out,
               dist_vizinho_out, relax_count_out
    );
    modport slave (
        output start_in, no_id_in, adj_rd_data_in, dist_rd_data_in, update_in, nova_dist_in,
        input  busy_out, done_out, adj_rd_en_out, adj_addr_out, dist_rd_en_out, dist_addr_out,
               dist_wr_en_out, dist_wr_data_out, dist_no_out, custo_vizinho_out,
               dist_vizinho_out, relax_count_out
    );
`endif
endinterface

// File: rtl/busca_vizinhos.sv
// busca_vizinhos: relaxes every neighbour of one node (one Dijkstra/Bellman
// step). Reads the node distance, walks its adjacency slots, reads each
// neighbour distance, lets the external PE decide, and writes improvements.
// Optional macro BUSCA_ANTECESSOR_EN adds predecessor write-back.
// o_state exposes the FSM state for debug.
module busca_vizinhos #(
    parameter int DIST_WIDTH   = 8,
    parameter int CUSTO_WIDTH  = 8,
    parameter int NO_WIDTH     = 5,
    parameter int MAX_VIZINHOS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    busca_vizinhos_if.master   bus,
    output logic [3:0]         o_state
);
    localparam int SLOT_W = $clog2(MAX_VIZINHOS);
    localparam int ADJ_W  = 1 + NO_WIDTH + CUSTO_WIDTH;
    localparam logic [DIST_WIDTH-1:0] INF = '1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD_NO   = 4'd1;
    localparam logic [3:0] S_LAT_NO  = 4'd2;
    localparam logic [3:0] S_RD_ADJ  = 4'd3;
    localparam logic [3:0] S_LAT_ADJ = 4'd4;
    localparam logic [3:0] S_RD_VIZ  = 4'd5;
    localparam logic [3:0] S_LAT_VIZ = 4'd6;
    localparam logic [3:0] S_AVALIA  = 4'd7;
    localparam logic [3:0] S_ESCREVE = 4'd8;
    localparam logic [3:0] S_FIM     = 4'd9;

    logic [3:0]             r_state;
    logic [NO_WIDTH-1:0]    r_no_id;
    logic [SLOT_W-1:0]      r_slot;
    logic [NO_WIDTH-1:0]    r_viz_id;
    logic [DIST_WIDTH-1:0]  r_dist_no;
    logic [CUSTO_WIDTH-1:0] r_custo;
    logic [DIST_WIDTH-1:0]  r_dist_viz;
    logic [DIST_WIDTH-1:0]  r_nova;
    logic [SLOT_W:0]        r_count;

    logic                   w_adj_valid;
    logic [NO_WIDTH-1:0]    w_adj_viz;
    logic [CUSTO_WIDTH-1:0] w_adj_custo;
    logic [DIST_WIDTH:0]    w_soma;
    logic                   w_cabe;
    logic                   w_ultimo;

    assign w_adj_valid = bus.adj_rd_data_in[ADJ_W-1];
    assign w_adj_viz   = bus.adj_rd_data_in[NO_WIDTH+CUSTO_WIDTH-1 -: NO_WIDTH];
    assign w_adj_custo = bus.adj_rd_data_in[CUSTO_WIDTH-1:0];

    // Sum carried one bit wider so an overflowing path can never be written.
    assign w_soma   = {1'b0, r_dist_no} + {{(DIST_WIDTH+1-CUSTO_WIDTH){1'b0}}, r_custo};
    assign w_cabe   = w_soma < {1'b0, INF};
    assign w_ultimo = r_slot == SLOT_W'(MAX_VIZINHOS-1);

    // Outputs are decoded from registered state only, so reset clears them at once.
    assign o_state               = r_state;
    assign bus.busy_out          = r_state != S_IDLE;
    assign bus.done_out          = r_state == S_FIM;
    assign bus.adj_rd_en_out     = r_state == S_RD_ADJ;
    assign bus.adj_addr_out      = {r_no_id, r_slot};
    assign bus.dist_rd_en_out    = (r_state == S_RD_NO) || (r_state == S_RD_VIZ);
    assign bus.dist_addr_out     = (r_state == S_RD_NO) ? r_no_id : r_viz_id;
    assign bus.dist_wr_en_out    = r_state == S_ESCREVE;
    assign bus.dist_wr_data_out  = r_nova;
    assign bus.dist_no_out       = r_dist_no;
    assign bus.custo_vizinho_out = r_custo;
    assign bus.dist_vizinho_out  = r_dist_viz;
    assign bus.relax_count_out   = r_count;
`ifdef BUSCA_ANTECESSOR_EN
    assign bus.pred_wr_en_out    = r_state == S_ESCREVE;
    assign bus.pred_wr_data_out  = r_no_id;
`endif

    // Control FSM and operand registers for one expansion run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_no_id    <= '0;
            r_slot     <= '0;
            r_viz_id   <= '0;
            r_dist_no  <= '0;
            r_custo    <= '0;
            r_dist_viz <= '0;
            r_nova     <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_in) begin
                        r_no_id <= bus.no_id_in;
                        r_slot  <= '0;
                        r_count <= '0;
                        r_state <= S_RD_NO;
                    end
                end
                S_RD_NO:  r_state <= S_LAT_NO;
                S_LAT_NO: begin
                    r_dist_no <= bus.dist_rd_data_in;
                    r_state   <= (bus.dist_rd_data_in == INF) ? S_FIM : S_RD_ADJ;
                end
                S_RD_ADJ:  r_state <= S_LAT_ADJ;
                S_LAT_ADJ: begin
                    if (w_adj_valid) begin
                        r_viz_id <= w_adj_viz;
                        r_custo  <= w_adj_custo;
                        r_state  <= S_RD_VIZ;
                    end else begin
                        r_state  <= S_FIM;
                    end
                end
                S_RD_VIZ:  r_state <= S_LAT_VIZ;
                S_LAT_VIZ: begin
                    r_dist_viz <= bus.dist_rd_data_in;
                    r_state    <= S_AVALIA;
                end
                S_AVALIA: begin
                    r_nova <= bus.nova_dist_in;
                    if (bus.update_in && w_cabe) begin
                        r_state <= S_ESCREVE;
                    end else if (w_ultimo) begin
                        r_state <= S_FIM;
                    end else begin
                        r_slot  <= r_slot + SLOT_W'(1);
                        r_state <= S_RD_ADJ;
                    end
                end
                S_ESCREVE: begin
                    r_count <= r_count + (SLOT_W+1)'(1);
                    if (w_ultimo) begin
                        r_state <= S_FIM;
                    end else begin
                        r_slot  <= r_slot + SLOT_W'(1);
                        r_state <= S_RD_ADJ;
                    end
                end
                S_FIM:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_busca_vizinhos.sv
// Testbench for busca_vizinhos: memory models, behavioural PE, queue-based
// scoreboard fed by a graph-walk reference model, directed and random runs.
module tb_busca_vizinhos;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int NW = 5;
    localparam int MV = 4;
    localparam int SW = 2;
    localparam int AW = NW + SW;
    localparam int NN = 1 << NW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    busca_vizinhos_if #(.DIST_WIDTH(DW), .CUSTO_WIDTH(CW), .NO_WIDTH(NW), .MAX_VIZINHOS(MV)) bus();
    logic [3:0] o_state;

    busca_vizinhos #(.DIST_WIDTH(DW), .CUSTO_WIDTH(CW), .NO_WIDTH(NW), .MAX_VIZINHOS(MV)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_state(o_state)
    );

    // ---------------- environment: memories and PE ----------------
    logic [NW+CW:0] adj_mem  [0:(1<<AW)-1];
    logic [DW-1:0]  dist_mem [0:NN-1];
    logic [DW-1:0]  dist_init[0:NN-1];
    logic           ld_all = 1'b0;

    always @(posedge clk) begin
        if (bus.adj_rd_en_out)  bus.adj_rd_data_in  <= adj_mem[bus.adj_addr_out];
        if (bus.dist_rd_en_out) bus.dist_rd_data_in <= dist_mem[bus.dist_addr_out];
        if (ld_all) begin
            for (int i = 0; i < NN; i++) dist_mem[i] <= dist_init[i];
        end else if (bus.dist_wr_en_out) begin
            dist_mem[bus.dist_addr_out] <= bus.dist_wr_data_out;
        end
    end

    // Plain PE: candidate = node distance + cost, truncated; improves if smaller.
    logic [DW:0] pe_sum;
    assign pe_sum           = {1'b0, bus.dist_no_out} + {1'b0, bus.custo_vizinho_out};
    assign bus.nova_dist_in = pe_sum[DW-1:0];
    assign bus.update_in    = pe_sum[DW-1:0] < bus.dist_vizinho_out;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [NW+DW-1:0] exp_wr_q[$];
    logic [AW-1:0]    exp_adj_q[$];
    logic [SW:0]      exp_cnt_q[$];
    int               exp_lat_q[$];
    int               accept_cyc = 0;
    logic [NW-1:0]    cur_node = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flush_q();
        exp_wr_q.delete();
        exp_adj_q.delete();
        exp_cnt_q.delete();
        exp_lat_q.delete();
    endtask

    // Monitor: compares every DUT-presented event against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            int n_en;
            n_en = int'(bus.adj_rd_en_out) + int'(bus.dist_rd_en_out) + int'(bus.dist_wr_en_out);
            if (n_en != 0) check("one_enable", 32'(n_en), 32'd1);
            if (bus.adj_rd_en_out) begin
                if (exp_adj_q.size() == 0) check("adj_unexpected", 32'd1, 32'd0);
                else check("adj_addr", 32'(bus.adj_addr_out), 32'(exp_adj_q.pop_front()));
            end
            if (bus.dist_wr_en_out) begin
                if (exp_wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else check("wr_addr_data", 32'({bus.dist_addr_out, bus.dist_wr_data_out}),
                           32'(exp_wr_q.pop_front()));
`ifdef BUSCA_ANTECESSOR_EN
                check("pred_wr", 32'({bus.pred_wr_en_out, bus.pred_wr_data_out}), 32'({1'b1, cur_node}));
`endif
            end
            if (bus.done_out) begin
                if (exp_cnt_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else begin
                    check("relax_count", 32'(bus.relax_count_out), 32'(exp_cnt_q.pop_front()));
                    check("done_latency", 32'(cyc - accept_cyc), 32'(exp_lat_q.pop_front()));
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Walks the node's adjacency list over a snapshot of the distance memory.
    // Latency is counted in clock edges from the accepting edge to done_out.
    task automatic model_push(input logic [NW-1:0] node);
        logic [DW-1:0] d[NN];
        logic [DW-1:0] dn;
        logic [NW+CW:0] e;
        logic [AW-1:0] a;
        logic [NW-1:0] v;
        logic [DW:0]   sum;
        int lat;
        int cnt;
        for (int i = 0; i < NN; i++) d[i] = dist_mem[i];
        dn  = d[node];
        lat = 2;
        cnt = 0;
        if (dn != '1) begin
            for (int s = 0; s < MV; s++) begin
                a = {node, s[SW-1:0]};
                exp_adj_q.push_back(a);
                e = adj_mem[a];
                lat += 2;
                if (!e[NW+CW]) break;
                lat += 3;
                v   = e[NW+CW-1:CW];
                sum = {1'b0, dn} + {1'b0, e[CW-1:0]};
                if ((sum[DW-1:0] < d[v]) && (sum < 9'd255)) begin
                    exp_wr_q.push_back({v, sum[DW-1:0]});
                    d[v] = sum[DW-1:0];
                    cnt++;
                    lat++;
                end
            end
        end
        exp_cnt_q.push_back(cnt[SW:0]);
        exp_lat_q.push_back(lat);
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_dist();
        @(negedge clk);
        ld_all = 1'b1;
        @(posedge clk);
        #1 ld_all = 1'b0;
    endtask

    task automatic set_adj(input int node, input int slot, input bit valid, input int v, input int c);
        logic [AW-1:0] a;
        a = AW'((node << SW) | slot);
        adj_mem[a] = {valid, NW'(v), CW'(c)};
    endtask

    task automatic clear_adj();
        for (int i = 0; i < (1 << AW); i++) adj_mem[i] = '0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (bus.busy_out && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue_start(input logic [NW-1:0] node, input bit hold);
        wait_idle();
        model_push(node);
        cur_node     = node;
        bus.start_in = 1'b1;
        bus.no_id_in = node;
        @(posedge clk);
        #1 accept_cyc = cyc;
        if (!hold) begin
            bus.start_in = 1'b0;
            bus.no_id_in = NW'($urandom);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_cnt_q.size() != 0 && k < 300) begin
            @(negedge clk);
            #2 k++;
        end
        bus.start_in = 1'b0;
        if (k >= 300) begin
            check("done_timeout", 32'd0, 32'd1);
            flush_q();
        end
        check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
        check("adj_q_drained", 32'(exp_adj_q.size()), 32'd0);
    endtask

    task automatic run(input logic [NW-1:0] node, input bit hold);
        issue_start(node, hold);
        wait_done();
    endtask

    task automatic randomize_graph();
        for (int i = 0; i < NN; i++)
            dist_init[i] = ($urandom_range(0, 5) == 0) ? 8'hFF : DW'($urandom_range(0, 255));
        for (int n = 0; n < NN; n++)
            for (int s = 0; s < MV; s++)
                set_adj(n, s, $urandom_range(0, 4) != 0, $urandom_range(0, NN-1),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [NW-1:0] wa;
        logic [DW-1:0] pre;
        int k;
        bus.start_in = 1'b0;
        bus.no_id_in = '0;
        for (int i = 0; i < NN; i++) dist_init[i] = 8'hFF;
        clear_adj();

        #1;
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_done", 32'(bus.done_out), 32'd0);
        check("rst_wr_en", 32'(bus.dist_wr_en_out), 32'd0);
        check("rst_count", 32'(bus.relax_count_out), 32'd0);
        check("rst_dist_no", 32'(bus.dist_no_out), 32'd0);
        check("rst_state", 32'(o_state), 32'd0);
        load_dist();
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Two improving/non-improving neighbours then end of list.
        dist_init[3] = 8'd10; dist_init[5] = 8'd20; dist_init[7] = 8'd11;
        set_adj(3, 0, 1, 5, 4);
        set_adj(3, 1, 1, 7, 2);
        set_adj(3, 2, 0, 0, 0);
        // Unreachable node: adjacency must never be read.
        dist_init[9] = 8'hFF;
        set_adj(9, 0, 1, 5, 1);
        // Overflowing candidate that the PE would accept.
        dist_init[10] = 8'd250; dist_init[11] = 8'hFF;
        set_adj(10, 0, 1, 11, 10);
        // Full list at the top node id, every slot improving.
        dist_init[31] = 8'd0;
        for (int s = 0; s < MV; s++) begin
            dist_init[20+s] = 8'hFF;
            set_adj(31, s, 1, 20+s, s+1);
        end
        load_dist();

        run(5'd3, 1'b0);
        run(5'd9, 1'b0);
        run(5'd10, 1'b0);
        run(5'd31, 1'b0);
        check("mem_after_full", 32'({dist_mem[20], dist_mem[23]}), 32'({8'd1, 8'd4}));

        // start_in held through a whole run.
        load_dist();
        run(5'd3, 1'b1);
        @(negedge clk);
        check("hold_back_idle", 32'(bus.busy_out), 32'd0);

        // Reset asserted while a write is presented.
        load_dist();
        issue_start(5'd31, 1'b0);
        k = 0;
        @(negedge clk);
        while (!bus.dist_wr_en_out && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("reach_escreve", 32'd0, 32'd1);
        wa  = bus.dist_addr_out;
        pre = dist_mem[wa];
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(bus.dist_wr_en_out), 32'd0);
        check("mid_rst_busy", 32'(bus.busy_out), 32'd0);
        check("mid_rst_count", 32'(bus.relax_count_out), 32'd0);
        check("mid_rst_dist_no", 32'(bus.dist_no_out), 32'd0);
        flush_q();
        @(posedge clk);
        #1 check("mid_rst_no_write", 32'(dist_mem[wa]), 32'(pre));
        @(negedge clk);
        rst_n = 1'b1;
        load_dist();
        run(5'd31, 1'b0);

        // Random graphs.
        for (int r = 0; r < 40; r++) begin
            if (r % 8 == 0) begin
                randomize_graph();
                load_dist();
            end
            run(NW'($urandom_range(0, NN-1)), $urandom_range(0, 3) == 0);
        end

        #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/busca_vizinhos.md
BUSCA_VIZINHOS -- requirements
Module: busca_vizinhos

Interface
REQ-001 Parameter DIST_WIDTH, default 8, distance word width; all-ones = infinity (INF).
REQ-002 Parameter CUSTO_WIDTH, default 8, edge-cost width.
REQ-003 Parameter NO_WIDTH, default 5, node-id width.
REQ-004 Parameter MAX_VIZINHOS, default 4 (power of 2), adjacency slots per node; SLOT_W = log2(MAX_VIZINHOS).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock, all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start_in  in  1  request to relax all neighbours of no_id_in; sampled only in IDLE.
REQ-009 no_id_in  in  NO_WIDTH  node to expand.
REQ-010 busy_out  out  1  high in every state except IDLE.
REQ-011 done_out  out  1  one-cycle pulse in FIM.
REQ-012 adj_rd_en_out / adj_addr_out  out  1 / NO_WIDTH+SLOT_W  adjacency read, addr = {no_id, slot}.
REQ-013 adj_rd_data_in  in  1+NO_WIDTH+CUSTO_WIDTH  {valid, vizinho_id, custo}, valid one cycle after adj_rd_en_out.
REQ-014 dist_rd_en_out / dist_addr_out  out  1 / NO_WIDTH  distance-memory read (addr shared with write).
REQ-015 dist_rd_data_in  in  DIST_WIDTH  read data, valid one cycle after dist_rd_en_out.
REQ-016 dist_wr_en_out / dist_wr_data_out  out  1 / DIST_WIDTH  distance write-back.
REQ-017 dist_no_out, custo_vizinho_out, dist_vizinho_out  out  DIST_WIDTH, CUSTO_WIDTH, DIST_WIDTH  registered operands to the relaxation PE.
REQ-018 update_in / nova_dist_in  in  1 / DIST_WIDTH  combinational PE result.
REQ-019 relax_count_out  out  SLOT_W+1  number of writes in current/last run.

Function
REQ-020 FSM states: IDLE, RD_NO, LAT_NO, RD_ADJ, LAT_ADJ, RD_VIZ, LAT_VIZ, AVALIA, ESCREVE, FIM.
REQ-021 IDLE: start_in=1 -> latch no_id_in, clear slot and relax_count_out, go RD_NO; start_in in any other state is ignored.
REQ-022 RD_NO: dist_rd_en_out=1, dist_addr_out=no_id -> LAT_NO.
REQ-023 LAT_NO: register dist_no_out; if dist_no = INF -> FIM, else -> RD_ADJ.
REQ-024 RD_ADJ: adj_rd_en_out=1 -> LAT_ADJ; LAT_ADJ: register entry; valid=0 -> FIM (list ends), else -> RD_VIZ.
REQ-025 RD_VIZ: dist_rd_en_out=1, dist_addr_out=vizinho_id -> LAT_VIZ; LAT_VIZ: register dist_vizinho_out -> AVALIA.
REQ-026 AVALIA: register nova_dist_in; go ESCREVE iff update_in=1 and dist_no_out+custo_vizinho_out (DIST_WIDTH+1 bits) < INF; else advance.
REQ-027 ESCREVE: dist_wr_en_out=1, dist_addr_out=vizinho_id, data = registered nova_dist, relax_count_out+1; then advance.
REQ-028 Advance: slot = MAX_VIZINHOS-1 -> FIM; else slot+1 -> RD_ADJ (no wrap into next node's slots).
REQ-029 FIM: done_out=1 for exactly one cycle -> IDLE.
REQ-030 Read/write enables are single-cycle pulses; never two enables in one cycle.
REQ-031 Per neighbour: 5 cycles without write, 6 with; whole run = 3 + per-neighbour total + FIM.

Reset
REQ-032 rst_n=0 forces IDLE, slot=0, all outputs 0 (including relax_count_out, operand registers) immediately, also mid-run; no write completes after reset assertion.
REQ-033 First start_in is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro BUSCA_ANTECESSOR_EN defined: ports pred_wr_en_out (1) and pred_wr_data_out (NO_WIDTH) exist; pred_wr_en_out pulses with dist_wr_en_out, address dist_addr_out, data = no_id; reset 0.
REQ-035 Macro undefined: those ports and their logic are absent; all other behaviour identical.

Verification
REQ-036 Node 3, dist=10, slots {(5,cost 4,dist 20),(7,cost 2,dist 11),invalid} -> one write addr 5 data 14, no write to 7, done after 15 cycles, relax_count_out=1.
REQ-037 dist_no=INF (255) -> no adjacency read, done_out 3 cycles after start, zero writes.
REQ-038 dist_no=250, cost 10, neighbour INF, PE update=1 -> overflow, no write.
REQ-039 All 4 slots valid and improving -> 4 writes, adj_addr_out spans {no,0..3} only, relax_count_out=4.
REQ-040 rst_n low during ESCREVE -> dist_wr_en_out 0 immediately, busy_out 0, new start after release runs cleanly.
REQ-041 start_in held high during run -> ignored; exactly one done_out per accepted start.
